// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake bundle for serial_subtractor
// Overflow is carried only when SERSUB_OVF_EN is defined
interface serial_subtractor_if #(parameter int WIDTH = 8);
   logic start, bin, borrow, busy, done;
   logic [WIDTH-1:0] a, b, diff;
`ifdef SERSUB_OVF_EN
   logic overflow;
   modport master (output start, a, b, bin, input diff, borrow, busy, done, overflow);
   modport slave (input start, a, b, bin, output diff, borrow, busy, done, overflow);
`else
   modport master (output start, a, b, bin, input diff, borrow, busy, done);
   modport slave (input start, a, b, bin, output diff, borrow, busy, done);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, LSB first, one registered borrow
// SERSUB_OVF_EN adds a signed-overflow flag built from the captured operand MSBs
module serial_subtractor #(parameter int WIDTH = 8) (
   input logic clk,
   input logic rst,
   serial_subtractor_if.slave s
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a_sh, b_sh, res;
   logic [CW-1:0] cnt;
   logic br, d, br_nx;
`ifdef SERSUB_OVF_EN
   logic a_msb, b_msb;
`endif
   assign d = a_sh[0] ^ b_sh[0] ^ br;
   assign br_nx = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_sh <= '0;
         b_sh <= '0;
         res <= '0;
         cnt <= '0;
         br <= 1'b0;
         s.diff <= '0;
         s.borrow <= 1'b0;
         s.busy <= 1'b0;
         s.done <= 1'b0;
`ifdef SERSUB_OVF_EN
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         s.overflow <= 1'b0;
`endif
      end else begin
         // done lands in the IDLE cycle after DONE, so a new Start can follow it directly
         s.done <= state == DONE;
         case (state)
            IDLE: if (s.start) begin
               a_sh <= s.a;
               b_sh <= s.b;
               br <= s.bin;
               cnt <= '0;
               s.busy <= 1'b1;
               state <= SHIFT;
`ifdef SERSUB_OVF_EN
               a_msb <= s.a[WIDTH-1];
               b_msb <= s.b[WIDTH-1];
`endif
            end
            SHIFT: begin
               res <= {d, res[WIDTH-1:1]};
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br <= br_nx;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) state <= DONE;
            end
            DONE: begin
               s.diff <= res;
               s.borrow <= br;
               s.busy <= 1'b0;
               state <= IDLE;
`ifdef SERSUB_OVF_EN
               s.overflow <= (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: WIDTH=8 and WIDTH=16 instances against a cycle-count/arithmetic model
// Directed cases pin literal results; random sweeps cover 1000 operations per width
module tb_serial_subtractor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(8)) i8 ();
   serial_subtractor_if #(.WIDTH(16)) i16 ();
   serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .s(i8));
   serial_subtractor #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .s(i16));

   int errs = 0, chks = 0, cyc = 0, bcnt8 = 0, bcnt16 = 0;
   logic fin16 = 1'b0;
   logic pin_v = 1'b0;
   logic [8:0] pin = '0;
`ifdef SERSUB_OVF_EN
   logic pin_o = 1'b0;
`endif

   // model: result is plain A-B-Bin in WIDTH+1 bits, delivered WIDTH+1 edges after acceptance
   int p8 = 0, p16 = 0;
   logic [8:0] pend8 = '0;
   logic [16:0] pend16 = '0;
   logic am8 = 0, bm8 = 0, am16 = 0, bm16 = 0;
   logic e8_busy = 0, e8_done = 0, e8_bor = 0, e8_ovf = 0;
   logic e16_busy = 0, e16_done = 0, e16_bor = 0, e16_ovf = 0;
   logic [7:0] e8_diff = '0;
   logic [15:0] e16_diff = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         p8 = 0; p16 = 0;
         e8_busy = 0; e8_done = 0; e8_bor = 0; e8_ovf = 0; e8_diff = '0;
         e16_busy = 0; e16_done = 0; e16_bor = 0; e16_ovf = 0; e16_diff = '0;
      end else begin
         e8_done = 0;
         if (p8 == 0) begin
            if (i8.start) begin
               pend8 = {1'b0, i8.a} - {1'b0, i8.b} - 9'(i8.bin);
               am8 = i8.a[7]; bm8 = i8.b[7]; p8 = 1;
            end
         end else if (p8 == 9) begin
            e8_diff = pend8[7:0]; e8_bor = pend8[8];
            e8_ovf = (am8 != bm8) && (pend8[7] != am8);
            e8_done = 1; p8 = 0;
         end else p8++;
         e8_busy = p8 != 0;
         e16_done = 0;
         if (p16 == 0) begin
            if (i16.start) begin
               pend16 = {1'b0, i16.a} - {1'b0, i16.b} - 17'(i16.bin);
               am16 = i16.a[15]; bm16 = i16.b[15]; p16 = 1;
            end
         end else if (p16 == 17) begin
            e16_diff = pend16[15:0]; e16_bor = pend16[16];
            e16_ovf = (am16 != bm16) && (pend16[15] != am16);
            e16_done = 1; p16 = 0;
         end else p16++;
         e16_busy = p16 != 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (cyc > 60000) begin
         $display("FAIL watchdog: got %0d cycles expected under 60000", cyc);
         $fatal(1, "watchdog");
      end
      chk("busy8", 32'(i8.busy), 32'(e8_busy));
      chk("done8", 32'(i8.done), 32'(e8_done));
      chk("res8", 32'({i8.borrow, i8.diff}), 32'({e8_bor, e8_diff}));
      chk("busy16", 32'(i16.busy), 32'(e16_busy));
      chk("done16", 32'(i16.done), 32'(e16_done));
      chk("res16", 32'({i16.borrow, i16.diff}), 32'({e16_bor, e16_diff}));
`ifdef SERSUB_OVF_EN
      chk("ovf8", 32'(i8.overflow), 32'(e8_ovf));
      chk("ovf16", 32'(i16.overflow), 32'(e16_ovf));
      if (i8.done && pin_v) chk("pin_ovf8", 32'(i8.overflow), 32'(pin_o));
`endif
      if (i8.done && pin_v) chk("pin_res8", 32'({i8.borrow, i8.diff}), 32'(pin));
      if (i8.done) chk("busy_len8", bcnt8, 9);
      if (i16.done) chk("busy_len16", bcnt16, 17);
      bcnt8 = (rst || i8.done) ? 0 : bcnt8 + int'(i8.busy);
      bcnt16 = (rst || i16.done) ? 0 : bcnt16 + int'(i16.busy);
   end

   // mid: 0 plain, 1 re-pulse Start mid-flight, 2 reset in the 4th SHIFT cycle
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input int mid);
      i8.a = a; i8.b = b; i8.bin = bin; i8.start = 1'b1;
      @(posedge clk); #1;
      i8.start = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom); i8.bin = 1'($urandom);
      if (mid == 1) begin
         repeat (2) @(posedge clk);
         #1 i8.a = 8'd1; i8.b = 8'd1; i8.bin = 1'b0; i8.start = 1'b1;
         @(posedge clk); #1 i8.start = 1'b0;
      end else if (mid == 2) begin
         repeat (3) @(posedge clk);
         #2 rst = 1'b1;
         @(posedge clk); #1 rst = 1'b0;
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i8.done) break;
      end
      #1;
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin);
      i16.a = a; i16.b = b; i16.bin = bin; i16.start = 1'b1;
      @(posedge clk); #1;
      i16.start = 1'b0; i16.a = 16'($urandom); i16.b = 16'($urandom);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i16.done) break;
      end
      #1;
   endtask

   initial begin
      i8.start = 0; i8.a = '0; i8.b = '0; i8.bin = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      pin = {1'b0, 8'd63}; pin_v = 1'b1;
      op8(8'd100, 8'd37, 1'b0, 0);
      pin = {1'b1, 8'hFC};
      op8(8'd5, 8'd9, 1'b0, 0);
      pin = {1'b1, 8'hFF};
      op8(8'd0, 8'd0, 1'b1, 0);
      pin = {1'b0, 8'd63};
      op8(8'd100, 8'd37, 1'b0, 1);
      op8(8'd100, 8'd37, 1'b0, 2);
      pin = {1'b0, 8'd0};
      op8(8'd200, 8'd200, 1'b0, 0);
      pin = {1'b0, 8'h7F};
`ifdef SERSUB_OVF_EN
      pin_o = 1'b1;
`endif
      op8(8'h80, 8'h01, 1'b0, 0);
      pin_v = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         op8(8'($urandom), 8'($urandom), 1'($urandom), 0);
      end
      wait (fin16);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

   initial begin
      i16.start = 0; i16.a = '0; i16.b = '0; i16.bin = 0;
      repeat (5) @(posedge clk);
      #1;
      op16(16'h0000, 16'h0001, 1'b0);
      op16(16'h8000, 16'h0001, 1'b1);
      for (int n = 0; n < 1000; n++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         op16(16'($urandom), 16'($urandom), 1'($urandom));
      end
      fin16 = 1'b1;
   end
endmodule
